// File: rtl/thermo_ramp_encoder_pkg.sv
// Shared types and helpers for the thermometer ramp encoder.
package thermo_pkg;

  localparam int unsigned SETTLE_W     = 8;
  // Widest thermometer thermo_of can build; callers cast down to their width.
  localparam int unsigned THERMO_MAX_W = 256;

  typedef enum logic [1:0] {IDLE, STEP, SETTLE} ramp_state_t;

  // Thermometer word with bit i set iff i < level.
  function automatic logic [THERMO_MAX_W-1:0] thermo_of(input int unsigned level);
    logic [THERMO_MAX_W-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < THERMO_MAX_W; i++) begin
      t[i] = (i < level);
    end
    return t;
  endfunction

endpackage

// File: rtl/thermo_ramp_encoder_settle_timer.sv
// Settle interval counter: load on a step, count down, flag the final cycle.
module settle_timer
  import thermo_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_load,
  input  logic [SETTLE_W-1:0] i_load_val,
  output logic                o_done_c
);

  logic [SETTLE_W-1:0] r_cnt;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - SETTLE_W'(1);
    end
  end

  assign o_done_c = (r_cnt == SETTLE_W'(1));

endmodule

// File: rtl/thermo_ramp_encoder.sv
// Binary-to-thermometer encoder that walks one segment per step and holds
// for a settle interval after each step. Optional macro THERMO_BYPASS_EN adds
// bypass_i, which jumps straight to the target followed by one settle.
module thermo_ramp_encoder
  import thermo_pkg::*;
#(
  parameter int unsigned IN_WIDTH      = 32,
  parameter int unsigned BIN_WIDTH     = $clog2(IN_WIDTH + 1),
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef THERMO_BYPASS_EN
  input  logic                 bypass_i,
`endif
  input  logic [BIN_WIDTH-1:0] code_i,
  input  logic                 code_valid_i,
  output logic                 code_ready_o,
  output logic [IN_WIDTH-1:0]  thermo_o,
  output logic [BIN_WIDTH-1:0] level_o,
  output logic                 busy_o,
  output logic                 sat_o
);

  localparam logic [BIN_WIDTH-1:0] MAX_LEVEL   = BIN_WIDTH'(IN_WIDTH);
  localparam logic [SETTLE_W-1:0]  SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);
  localparam bit                   SETTLE_ZERO = (SETTLE_CYCLES == 0);

  ramp_state_t          r_state, w_state_nxt;
  logic [BIN_WIDTH-1:0] r_target, w_target_nxt;
  logic [BIN_WIDTH-1:0] r_level, w_level_nxt;
  logic [IN_WIDTH-1:0]  r_thermo;
  logic                 r_sat, w_sat_nxt;
  logic                 r_bypass, w_bypass_nxt;
  logic                 r_ready, w_ready_nxt;
  logic                 r_busy, w_busy_nxt;

  logic                 w_bypass_in;
  logic                 w_code_over;
  logic [BIN_WIDTH-1:0] w_code_sat;
  logic [BIN_WIDTH-1:0] w_step_level;
  logic                 w_settle_done;

`ifdef THERMO_BYPASS_EN
  assign w_bypass_in = bypass_i;
`else
  assign w_bypass_in = 1'b0;
`endif

  // Clamp the incoming code before any comparison so level never overruns.
  assign w_code_over = (code_i > MAX_LEVEL);
  assign w_code_sat  = w_code_over ? MAX_LEVEL : code_i;

  // Level after a step: one segment toward target, or straight there on bypass.
  assign w_step_level = r_bypass ? r_target :
                        (r_target > r_level) ? r_level + BIN_WIDTH'(1) :
                                               r_level - BIN_WIDTH'(1);

  settle_timer u_settle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (r_state == STEP),
    .i_load_val (SETTLE_LOAD),
    .o_done_c   (w_settle_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (code_valid_i && (w_code_sat != r_level)) begin
          w_state_nxt = STEP;
        end
      end
      STEP: begin
        if (SETTLE_ZERO) begin
          w_state_nxt = (w_step_level != r_target) ? STEP : IDLE;
        end else begin
          w_state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (w_settle_done) begin
          w_state_nxt = (r_level != r_target) ? STEP : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered datapath and status outputs.
  always_comb begin
    w_target_nxt = r_target;
    w_level_nxt  = r_level;
    w_sat_nxt    = r_sat;
    w_bypass_nxt = r_bypass;
    if ((r_state == IDLE) && code_valid_i) begin
      w_target_nxt = w_code_sat;
      w_sat_nxt    = r_sat | w_code_over;
      w_bypass_nxt = w_bypass_in;
    end
    if (r_state == STEP) begin
      w_level_nxt = w_step_level;
    end
    w_ready_nxt = (w_state_nxt == IDLE);
    w_busy_nxt  = (w_state_nxt != IDLE);
  end

  // Output and datapath registers; reset drops every segment at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target <= '0;
      r_level  <= '0;
      r_thermo <= '0;
      r_sat    <= 1'b0;
      r_bypass <= 1'b0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_target <= w_target_nxt;
      r_level  <= w_level_nxt;
      r_thermo <= IN_WIDTH'(thermo_of(32'(w_level_nxt)));
      r_sat    <= w_sat_nxt;
      r_bypass <= w_bypass_nxt;
      r_ready  <= w_ready_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign code_ready_o = r_ready;
  assign thermo_o     = r_thermo;
  assign level_o      = r_level;
  assign busy_o       = r_busy;
  assign sat_o        = r_sat;

endmodule

// File: tb/tb_thermo_ramp_encoder.sv
// Scoreboard bench for thermo_ramp_encoder (default build, ramp mode).
module tb_thermo_ramp_encoder;

  localparam int unsigned IN_W   = 32;
  localparam int unsigned BIN_W  = 6;
  localparam int unsigned S      = 4;
  localparam int unsigned STEP_T = S + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [BIN_W-1:0] code = '0;
  logic             code_valid = 1'b0;
  logic             bypass = 1'b0;
  logic             code_ready;
  logic [IN_W-1:0]  thermo;
  logic [BIN_W-1:0] level;
  logic             busy;
  logic             sat;

  thermo_ramp_encoder #(
    .IN_WIDTH      (IN_W),
    .BIN_WIDTH     (BIN_W),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef THERMO_BYPASS_EN
    .bypass_i     (bypass),
`endif
    .code_i       (code),
    .code_valid_i (code_valid),
    .code_ready_o (code_ready),
    .thermo_o     (thermo),
    .level_o      (level),
    .busy_o       (busy),
    .sat_o        (sat)
  );

  always #5 clk = ~clk;

  typedef struct { int unsigned edge_no; int unsigned lvl; } step_t;
  typedef struct { int unsigned edge_no; int unsigned lvl; bit sat; } done_t;

  step_t       step_q[$];
  done_t       done_q[$];
  step_t       s_pop;
  done_t       d_pop;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned edge_cnt = 0;
  int unsigned m_level = 0;
  bit          m_sat = 1'b0;
  bit          mon_en = 1'b0;
  logic [IN_W-1:0] prev_thermo = '0;
  logic        prev_ready = 1'b1;

  always @(posedge clk) edge_cnt++;

  function automatic logic [31:0] exp_thermo(input int unsigned l);
    logic [63:0] v;
    v = (64'd1 << l) - 64'd1;
    return v[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (edge %0d)", name, edge_cnt);
  endtask

  // Monitor: every thermometer change and every ready return is matched
  // against the next expected event from the scoreboard queues.
  always @(negedge clk) begin
    if (mon_en) begin
      check("thermo_vs_level", 64'(thermo), 64'(exp_thermo(32'(level))));
      check("busy_vs_ready", 64'(busy), 64'(!code_ready));
      if (thermo !== prev_thermo) begin
        if (step_q.size() == 0) begin
          fail_now("unexpected_thermo_change");
        end else begin
          s_pop = step_q.pop_front();
          check("step_edge", 64'(edge_cnt), 64'(s_pop.edge_no));
          check("step_level", 64'(level), 64'(s_pop.lvl));
          check("step_thermo", 64'(thermo), 64'(exp_thermo(s_pop.lvl)));
        end
      end
      if (code_ready && !prev_ready) begin
        if (done_q.size() == 0) begin
          fail_now("unexpected_ready_return");
        end else begin
          d_pop = done_q.pop_front();
          check("done_edge", 64'(edge_cnt), 64'(d_pop.edge_no));
          check("done_level", 64'(level), 64'(d_pop.lvl));
          check("done_sat", 64'(sat), 64'(d_pop.sat));
        end
      end
    end
    prev_thermo = thermo;
    prev_ready  = code_ready;
  end

  task automatic wait_idle();
    int unsigned n = 0;
    while ((step_q.size() != 0 || done_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (step_q.size() != 0 || done_q.size() != 0) fail_now("idle_timeout");
    @(negedge clk);
  endtask

  // Issue one code and push the expected step/done events from the model.
  task automatic send(input int unsigned c, input bit wait_done);
    int unsigned n = 0;
    int unsigned t, a, d;
    @(negedge clk);
    while (!code_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!code_ready) fail_now("ready_timeout");
    code       = BIN_W'(c);
    code_valid = 1'b1;
    a = edge_cnt + 1;
    t = (c > IN_W) ? IN_W : c;
    if (c > IN_W) m_sat = 1'b1;
    d = (t > m_level) ? t - m_level : m_level - t;
    for (int unsigned k = 1; k <= d; k++) begin
      step_q.push_back('{a + (k - 1) * STEP_T + 1,
                         (t > m_level) ? m_level + k : m_level - k});
    end
    if (d > 0) done_q.push_back('{a + d * STEP_T, t, m_sat});
    m_level = t;
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    code       = BIN_W'($urandom);
    if (wait_done) wait_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    repeat (3) @(negedge clk);
    check("rst_thermo", 64'(thermo), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_ready", 64'(code_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sat", 64'(sat), 64'd0);
    rst_n  = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    send(5, 1'b1);
    // Code equal to the current level: nothing moves, ready never drops.
    send(5, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("eq_ready", 64'(code_ready), 64'd1);
      check("eq_thermo", 64'(thermo), 64'h1F);
    end
    send(2, 1'b1);
    send(40, 1'b1);
    check("sat_full_thermo", 64'(thermo), 64'hFFFF_FFFF);
    send(32, 1'b1);
    send(0, 1'b1);
    check("sat_sticky", 64'(sat), 64'd1);

    // Mid-settle reset at level 12, with a code pulsed while busy.
    send(30, 1'b0);
    repeat (3) @(negedge clk);
    code       = BIN_W'(3);
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    n = 0;
    while (level != BIN_W'(12) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (level != BIN_W'(12)) fail_now("level12_timeout");
    repeat (2) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_thermo", 64'(thermo), 64'd0);
    check("async_rst_level", 64'(level), 64'd0);
    check("async_rst_ready", 64'(code_ready), 64'd1);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_sat", 64'(sat), 64'd0);
    step_q.delete();
    done_q.delete();
    m_level = 0;
    m_sat   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    send(3, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send($urandom_range(0, 40), 1'b1);
    end
    check("final_level", 64'(level), 64'(m_level));
    check("final_sat", 64'(sat), 64'(m_sat));
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
